fifo_drain_master: RTL and testbench
====================================

Name: fifo_drain_master

Overview:
- Consumer-side engine for the 16-entry, 32-bit FIFO (fifo_16). The engine pops a commanded number of words and writes each one to an incrementing bus address as a bus master, using a request/grant handshake.
- It forms the read half of the DMA datapath; the producer pushes words through wr_en/d_in at the other end.
- Command in, one done or err pulse out.

Parameters:
- ADDR_STEP, 4, byte increment applied to m_addr after each completed bus write.
- MAX_SIZE, 16, largest legal op_size; larger values are clamped to this.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- op_start  input  1  one-cycle command strobe, sampled only in IDLE.
- op_dest_addr  input  32  start byte address, latched on accepted op_start.
- op_size  input  5  words to transfer (0..16), latched on accepted op_start.
- fifo_rd_en  output  1  FIFO pop request.
- fifo_d_out  input  32  FIFO read data.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_ack  input  1  FIFO read-succeeded flag.
- fifo_rd_err  input  1  FIFO read-on-empty flag.
- m_req  output  1  bus request.
- m_grant  input  1  bus grant.
- m_wr  output  1  bus write strobe, one cycle per word.
- m_addr  output  32  bus write address.
- m_dout  output  32  bus write data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  one-cycle pulse on aborted transfer.

Behaviour:
- Reset (asynchronous, reset_n low): state goes to IDLE. All outputs are 0, including m_addr and m_dout. Internal address, count and data registers are cleared.
- Reset asserted mid-operation aborts the transfer immediately. No done or err pulse is produced. Any word already popped is discarded.
- FIFO timing: fifo_rd_en sampled at edge N. fifo_d_out and fifo_rd_ack (or fifo_rd_err) are valid during cycle N+1.
- fifo_rd_en is never asserted for more than one consecutive cycle.
- States: IDLE, REQ, POP, WAIT, WRITE, DONE, ERR.
- IDLE, op_start=1, op_size=0: go to DONE. No bus request and no pop are issued.
- IDLE, op_start=1, op_size>0: latch the address and min(op_size, MAX_SIZE), then go to REQ.
- op_start in any state other than IDLE is ignored.
- REQ: m_req=1. On m_grant=1 go to POP. m_req stays 1 from REQ until exit from DONE or ERR.
- POP: if fifo_empty=1, stay in POP with fifo_rd_en=0; the engine stalls indefinitely and this is not an error. If fifo_empty=0, assert fifo_rd_en for one cycle and go to WAIT.
- WAIT, fifo_rd_ack=1: capture fifo_d_out into the data register, go to WRITE.
- WAIT, fifo_rd_err=1: go to ERR. A fifo_rd_err seen in any other state is ignored.
- WRITE with m_grant=1: m_wr=1 for exactly that cycle, m_addr=current address, m_dout=captured word. Then address += ADDR_STEP (wraps modulo 2^32) and count -= 1. If the new count is 0 go to DONE, else go to POP.
- WRITE with m_grant=0: hold m_wr=0 with m_addr and m_dout stable until grant returns.
- DONE: done=1 for one cycle, m_req drops, go to IDLE.
- ERR: err=1 for one cycle, m_req drops, go to IDLE. The remaining count is discarded.
- Minimum cost per word, grant held and FIFO non-empty: 3 cycles (POP, WAIT, WRITE).
- m_addr and m_dout hold their last values outside WRITE. They are only meaningful while m_wr=1.

Test Plan:
- Reset mid-operation: reset_n pulsed low while in WAIT -> all outputs 0 at once; no done, no err; next op_start is accepted normally.
- Basic transfer: FIFO preloaded with 10000000, 20000000, 30000000, 40000000; op_dest_addr=0x100, op_size=4; m_grant tied 1 -> four m_wr pulses at 0x100/0x104/0x108/0x10C carrying those values in order; done one cycle later; fifo data_count returns to 0.
- Zero size: op_size=0 -> done pulses 2 cycles after op_start (IDLE, DONE); m_req, fifo_rd_en and m_wr never assert.
- Empty stall: op_size=2 with FIFO empty; push 50000000 after 20 cycles, 60000000 after 40 cycles -> fifo_rd_en stays 0 while empty; two writes follow with the correct data; done pulses; err never pulses.
- Grant stall and wrap: op_dest_addr=0xFFFFFFFC, op_size=2, m_grant deasserted for 5 cycles during the first WRITE -> m_wr held until grant returns; writes land at 0xFFFFFFFC then 0x00000000.
- Read error: force fifo_rd_err=1 in the WAIT cycle of word 3 of 16 -> exactly 2 m_wr pulses, then err pulses once, m_req drops, busy falls; op_start during the transfer has no effect.

Source files
------------

// File: rtl/fifo_drain_master.sv
// fifo_drain_master: pops a commanded number of 32-bit words from fifo_16 and
// writes each one to an incrementing bus address through a request/grant master.
module fifo_drain_master #(
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned MAX_SIZE  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_start,
    input  logic [31:0] op_dest_addr,
    input  logic [4:0]  op_size,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_d_out,
    input  logic        fifo_empty,
    input  logic        fifo_rd_ack,
    input  logic        fifo_rd_err,
    output logic        m_req,
    input  logic        m_grant,
    output logic        m_wr,
    output logic [31:0] m_addr,
    output logic [31:0] m_dout,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_POP,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [31:0] STEP     = 32'(ADDR_STEP);
    localparam logic [4:0]  SIZE_CAP = 5'(MAX_SIZE);

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] m_addr_q;
    logic [31:0] data_q;
    logic [4:0]  count_q;
    logic        m_req_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    // NOTE: fifo_rd_en and m_wr are decoded from the current state and the
    // same-cycle fifo_empty / m_grant; registering them would cost an extra
    // cycle per word and could pop or write on stale flags.
    assign fifo_rd_en = (state_q == S_POP) && !fifo_empty;
    assign m_wr       = (state_q == S_WRITE) && m_grant;

    assign m_req  = m_req_q;
    assign m_addr = m_addr_q;
    assign m_dout = data_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

    // NOTE: all state is non-blocking and asynchronously cleared, including the
    // address and data registers, so an aborted transfer leaves nothing behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            m_addr_q <= '0;
            data_q   <= '0;
            count_q  <= '0;
            m_req_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (op_start) begin
                        busy_q <= 1'b1;
                        if (op_size == 5'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_REQ;
                            m_req_q <= 1'b1;
                            addr_q  <= op_dest_addr;
                            count_q <= (op_size > SIZE_CAP) ? SIZE_CAP : op_size;
                        end
                    end
                end
                S_REQ: begin
                    if (m_grant) begin
                        state_q <= S_POP;
                    end
                end
                S_POP: begin
                    if (!fifo_empty) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A read error wins over an ack if both ever appear together.
                    if (fifo_rd_err) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end else if (fifo_rd_ack) begin
                        state_q  <= S_WRITE;
                        data_q   <= fifo_d_out;
                        m_addr_q <= addr_q;
                    end
                end
                S_WRITE: begin
                    if (m_grant) begin
                        addr_q  <= addr_q + STEP;
                        count_q <= count_q - 5'd1;
                        if (count_q == 5'd1) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_POP;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    state_q <= S_IDLE;
                    m_req_q <= 1'b0;
                    busy_q  <= 1'b0;
                    count_q <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    m_req_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_master.sv
// tb_fifo_drain_master: directed bench for fifo_drain_master with a small
// behavioural fifo_16 model and a negedge bus monitor.
module tb_fifo_drain_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_start;
    logic [31:0] op_dest_addr;
    logic [4:0]  op_size;
    logic        fifo_rd_en;
    logic [31:0] fifo_d_out;
    logic        fifo_empty;
    logic        fifo_rd_ack;
    logic        fifo_rd_err;
    logic        m_req;
    logic        m_grant;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_dout;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    fifo_drain_master #(.ADDR_STEP(4), .MAX_SIZE(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (op_start),
        .op_dest_addr (op_dest_addr),
        .op_size      (op_size),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_d_out   (fifo_d_out),
        .fifo_empty   (fifo_empty),
        .fifo_rd_ack  (fifo_rd_ack),
        .fifo_rd_err  (fifo_rd_err),
        .m_req        (m_req),
        .m_grant      (m_grant),
        .m_wr         (m_wr),
        .m_addr       (m_addr),
        .m_dout       (m_dout),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    // Behavioural 16-deep FIFO: pop sampled at edge N, data/ack/err valid in N+1.
    logic        fifo_wr_en;
    logic [31:0] fifo_d_in;
    logic        inj_err;
    logic [31:0] mdl_mem [16];
    logic [3:0]  mdl_wp = '0;
    logic [3:0]  mdl_rp = '0;
    int          mdl_count = 0;
    logic [31:0] mdl_dout = '0;
    logic        mdl_ack = 1'b0;
    logic        mdl_err = 1'b0;

    assign fifo_d_out  = mdl_dout;
    assign fifo_empty  = (mdl_count == 0);
    assign fifo_rd_ack = mdl_ack && !inj_err;
    assign fifo_rd_err = mdl_err || inj_err;

    always @(posedge clk) begin
        if (fifo_wr_en) begin
            mdl_mem[mdl_wp] <= fifo_d_in;
            mdl_wp <= mdl_wp + 4'd1;
        end
        mdl_ack <= 1'b0;
        mdl_err <= 1'b0;
        if (fifo_rd_en) begin
            if (mdl_count > 0) begin
                mdl_dout <= mdl_mem[mdl_rp];
                mdl_rp   <= mdl_rp + 4'd1;
                mdl_ack  <= 1'b1;
            end else begin
                mdl_err <= 1'b1;
            end
        end
        mdl_count <= mdl_count + (fifo_wr_en ? 1 : 0) - ((fifo_rd_en && mdl_count > 0) ? 1 : 0);
    end

    // Bus/handshake monitor, sampled on the falling edge.
    int          cyc = 0;
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          wr_cyc_q [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          err_cnt = 0;
    int          rd_en_cnt = 0;
    int          req_cnt = 0;
    int          rd_empty_viol = 0;
    int          rd_back2back = 0;
    logic        rd_en_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_wr) begin
            wr_addr_q.push_back(m_addr);
            wr_data_q.push_back(m_dout);
            wr_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (err) err_cnt = err_cnt + 1;
        if (m_req) req_cnt = req_cnt + 1;
        if (fifo_rd_en) rd_en_cnt = rd_en_cnt + 1;
        if (fifo_rd_en && fifo_empty) rd_empty_viol = rd_empty_viol + 1;
        if (fifo_rd_en && rd_en_prev) rd_back2back = rd_back2back + 1;
        rd_en_prev = fifo_rd_en;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        fifo_wr_en = 1'b1;
        fifo_d_in  = d;
        step();
        fifo_wr_en = 1'b0;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [4:0] s);
        op_start     = 1'b1;
        op_dest_addr = a;
        op_size      = s;
        step();
        op_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base = done_cnt;
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (done_cnt != base) seen = 1'b1;
        end
        check({tag, "_done_timeout"}, 64'(seen), 64'(1));
    endtask

    task automatic wait_rd_en(input string tag, input int n, input int base);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (rd_en_cnt - base >= n) seen = 1'b1;
            else step();
        end
        check({tag, "_rd_en_timeout"}, 64'(seen), 64'(1));
    endtask

    task automatic check_write(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < wr_addr_q.size()) begin
            check({tag, "_addr"}, 64'(wr_addr_q[idx]), 64'(a));
            check({tag, "_data"}, 64'(wr_data_q[idx]), 64'(d));
        end else begin
            check({tag, "_missing"}, 64'(wr_addr_q.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        int wb, db, eb, rb, qb;
        reset_n = 1'b0; op_start = 1'b0; op_dest_addr = '0; op_size = '0;
        m_grant = 1'b0; fifo_wr_en = 1'b0; fifo_d_in = '0; inj_err = 1'b0;
        repeat (3) step();
        check("rst_ctrl", 64'({busy, m_req, fifo_rd_en, m_wr, done, err}), 64'(0));
        check("rst_addr", 64'(m_addr), 64'(0));
        check("rst_dout", 64'(m_dout), 64'(0));
        reset_n = 1'b1;
        repeat (2) step();

        // Basic four-word transfer with grant held.
        m_grant = 1'b1;
        for (int k = 0; k < 4; k++) push(32'h1000_0000 * (k + 1));
        wb = wr_addr_q.size(); eb = err_cnt;
        start_op(32'h100, 5'd4);
        check("basic_busy", 64'(busy), 64'(1));
        check("basic_req", 64'(m_req), 64'(1));
        wait_done("basic", 40);
        check("basic_nwr", 64'(wr_addr_q.size() - wb), 64'(4));
        for (int k = 0; k < 4; k++) check_write("basic_wr", wb + k, 32'h100 + 32'(4 * k), 32'h1000_0000 * (k + 1));
        for (int k = 1; k < 4; k++) check("basic_gap", 64'(wr_cyc_q[wb + k] - wr_cyc_q[wb + k - 1]), 64'(3));
        check("basic_done_lat", 64'(done_cyc - wr_cyc_q[wb + 3]), 64'(1));
        check("basic_fifo_cnt", 64'(mdl_count), 64'(0));
        check("basic_err", 64'(err_cnt - eb), 64'(0));
        check("basic_idle", 64'({busy, m_req, done}), 64'(0));

        // Zero size: straight to DONE, no request, pop or write.
        wb = wr_addr_q.size(); db = done_cnt; rb = rd_en_cnt; qb = req_cnt;
        start_op(32'h200, 5'd0);
        check("zero_done", 64'(done), 64'(1));
        check("zero_busy", 64'(busy), 64'(1));
        step();
        check("zero_done_end", 64'({done, busy}), 64'(0));
        repeat (2) step();
        check("zero_req", 64'(req_cnt - qb), 64'(0));
        check("zero_rd_en", 64'(rd_en_cnt - rb), 64'(0));
        check("zero_nwr", 64'(wr_addr_q.size() - wb), 64'(0));
        check("zero_ndone", 64'(done_cnt - db), 64'(1));

        // Empty stall: engine waits in POP until words arrive.
        wb = wr_addr_q.size(); db = done_cnt; eb = err_cnt; rb = rd_en_cnt;
        start_op(32'h300, 5'd2);
        repeat (18) step();
        check("stall_rd_en", 64'(rd_en_cnt - rb), 64'(0));
        check("stall_busy", 64'(busy), 64'(1));
        push(32'h5000_0000);
        repeat (19) step();
        push(32'h6000_0000);
        wait_done("stall", 40);
        check("stall_nwr", 64'(wr_addr_q.size() - wb), 64'(2));
        check_write("stall_wr0", wb, 32'h300, 32'h5000_0000);
        check_write("stall_wr1", wb + 1, 32'h304, 32'h6000_0000);
        check("stall_err", 64'(err_cnt - eb), 64'(0));
        check("stall_ndone", 64'(done_cnt - db), 64'(1));

        // Grant withdrawn for five WRITE cycles, address wraps.
        push(32'hA1A1_0001);
        push(32'hA2A2_0002);
        wb = wr_addr_q.size(); rb = rd_en_cnt;
        start_op(32'hFFFF_FFFC, 5'd2);
        wait_rd_en("wrap", 1, rb);
        m_grant = 1'b0;
        repeat (6) step();
        check("wrap_hold_wr", 64'(m_wr), 64'(0));
        check("wrap_hold_nwr", 64'(wr_addr_q.size() - wb), 64'(0));
        check("wrap_hold_addr", 64'(m_addr), 64'(32'hFFFF_FFFC));
        check("wrap_hold_dout", 64'(m_dout), 64'(32'hA1A1_0001));
        m_grant = 1'b1;
        #1;
        check("wrap_release_wr", 64'(m_wr), 64'(1));
        wait_done("wrap", 20);
        check_write("wrap_wr0", wb, 32'hFFFF_FFFC, 32'hA1A1_0001);
        check_write("wrap_wr1", wb + 1, 32'h0000_0000, 32'hA2A2_0002);

        // Oversized op_size is clamped to 16 words.
        for (int k = 0; k < 16; k++) push(32'hD000_0000 + 32'(k));
        wb = wr_addr_q.size();
        start_op(32'h2000, 5'd20);
        wait_done("clamp", 120);
        check("clamp_nwr", 64'(wr_addr_q.size() - wb), 64'(16));
        check_write("clamp_first", wb, 32'h2000, 32'hD000_0000);
        check_write("clamp_last", wb + 15, 32'h203C, 32'hD000_000F);
        check("clamp_fifo_cnt", 64'(mdl_count), 64'(0));

        // Read error on the third word; op_start during the transfer is ignored.
        push(32'hC1C1_0001);
        push(32'hC2C2_0002);
        push(32'hC3C3_0003);
        wb = wr_addr_q.size(); db = done_cnt; eb = err_cnt; rb = rd_en_cnt;
        start_op(32'h3000, 5'd16);
        wait_rd_en("rderr", 3, rb);
        inj_err = 1'b1; op_start = 1'b1; op_size = 5'd0; op_dest_addr = '0;
        step();
        inj_err = 1'b0; op_start = 1'b0;
        check("rderr_err", 64'(err), 64'(1));
        check("rderr_req_in_err", 64'({m_req, busy, done}), 64'(3'b110));
        step();
        check("rderr_after", 64'({err, m_req, busy}), 64'(0));
        repeat (3) step();
        check("rderr_nwr", 64'(wr_addr_q.size() - wb), 64'(2));
        check_write("rderr_wr0", wb, 32'h3000, 32'hC1C1_0001);
        check_write("rderr_wr1", wb + 1, 32'h3004, 32'hC2C2_0002);
        check("rderr_nerr", 64'(err_cnt - eb), 64'(1));
        check("rderr_ndone", 64'(done_cnt - db), 64'(0));

        // Reset asserted in WAIT aborts silently; next command works.
        push(32'h5555_0001);
        wb = wr_addr_q.size(); db = done_cnt; eb = err_cnt; rb = rd_en_cnt;
        start_op(32'h500, 5'd1);
        wait_rd_en("rstmid", 1, rb);
        reset_n = 1'b0;
        #1;
        check("rstmid_ctrl", 64'({busy, m_req, fifo_rd_en, m_wr, done, err}), 64'(0));
        check("rstmid_addr", 64'(m_addr), 64'(0));
        check("rstmid_dout", 64'(m_dout), 64'(0));
        step();
        repeat (2) step();
        reset_n = 1'b1;
        repeat (4) step();
        check("rstmid_ndone", 64'(done_cnt - db), 64'(0));
        check("rstmid_nerr", 64'(err_cnt - eb), 64'(0));
        check("rstmid_nwr", 64'(wr_addr_q.size() - wb), 64'(0));
        check("rstmid_fifo_cnt", 64'(mdl_count), 64'(0));
        push(32'h6666_0001);
        start_op(32'h40, 5'd1);
        wait_done("recover", 20);
        check_write("recover_wr", wb, 32'h40, 32'h6666_0001);

        check("rd_en_back2back", 64'(rd_back2back), 64'(0));
        check("rd_en_on_empty", 64'(rd_empty_viol), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
